// File: rtl/ahb_sub_mem.sv
// ahb_sub_mem: AHB-Lite subordinate backed by a Depth x DataWidth register file.
// The OKAY data phase stretches by WaitStates cycles. Sized writes update only
// the byte lanes the access covers. An illegal access gets a two-cycle ERROR
// response.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   sel, readyIn      decoder select and bus-level HREADY
//   addr, trans,
//   write, size       address-phase controls
//   wData             write data, sampled in the final data-phase cycle only
//   rData             read data: the stored word during a read's final data
//                     cycle, otherwise 0
//   resp, readyOut    HRESP (00 OKAY, 01 ERROR) and HREADYOUT

// One byte column of the memory. Each column holds byte <lane> of every word.
module ahb_sub_mem_lane #(
  parameter int Depth = 256,
  parameter int IdxW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [IdxW-1:0] idx,
  input  logic [7:0]      d,
  output logic [7:0]      q
);
  logic [7:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= d;
    end
  end

  assign q = mem[idx];
endmodule

module ahb_sub_mem #(
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 32,
  parameter int Depth      = 256,
  parameter int WaitStates = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 readyIn,
  input  logic [AddrWidth-1:0] addr,
  input  logic [1:0]           trans,
  input  logic                 write,
  input  logic [2:0]           size,
  input  logic [DataWidth-1:0] wData,
  output logic [DataWidth-1:0] rData,
  output logic [1:0]           resp,
  output logic                 readyOut
);
  localparam int NL = DataWidth / 8;
  localparam int BL = $clog2(NL);
  localparam int OW = (BL > 0) ? BL : 1;
  localparam int IW = $clog2(Depth);
  localparam logic [3:0] WsInit = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [IW-1:0]   cap_idx;
  logic [OW-1:0]   cap_off;
  logic [2:0]      cap_size;
  logic            cap_write;

  logic                 accept, legal;
  logic [AddrWidth-1:0] word_idx, amask;
  logic [NL-1:0]        lane_en;
  logic [NL-1:0][7:0]   rd_word;

  // trans[0] only separates NONSEQ from SEQ and IDLE from BUSY, and the
  // subordinate handles both members of each pair the same way.
  logic unused_trans;
  assign unused_trans = trans[0];

  assign accept   = sel && readyIn && trans[1];
  assign word_idx = addr >> BL;
  assign amask    = (AddrWidth'(1) << size) - AddrWidth'(1);
  assign legal    = (size <= 3'(BL)) && ((addr & amask) == '0) &&
                    (word_idx < AddrWidth'(Depth));

  // Aligned accesses cover the contiguous lanes [off, off + 2^size).
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < NL; i++)
      lane_en[i] = (32'(i) >= 32'(cap_off)) &&
                   (32'(i) < 32'(cap_off) + (32'd1 << cap_size));
  end

  // Accepts are taken only where readyOut is high: IDLE, DATA and ERR2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      readyOut  <= 1'b1;
      resp      <= 2'b00;
      cap_idx   <= '0;
      cap_off   <= '0;
      cap_size  <= '0;
      cap_write <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == '0) begin
            state    <= S_DATA;
            readyOut <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state    <= S_ERR2;
          readyOut <= 1'b1;
          resp     <= 2'b01;
        end
        default: begin
          if (accept) begin
            cap_idx   <= word_idx[IW-1:0];
            cap_off   <= (BL > 0) ? addr[OW-1:0] : '0;
            cap_size  <= size;
            cap_write <= write;
            if (!legal) begin
              state    <= S_ERR1;
              readyOut <= 1'b0;
              resp     <= 2'b01;
            end else if (WaitStates > 0) begin
              state    <= S_WAIT;
              cnt      <= WsInit;
              readyOut <= 1'b0;
              resp     <= 2'b00;
            end else begin
              state    <= S_DATA;
              readyOut <= 1'b1;
              resp     <= 2'b00;
            end
          end else begin
            state    <= S_IDLE;
            readyOut <= 1'b1;
            resp     <= 2'b00;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    ahb_sub_mem_lane #(.Depth(Depth), .IdxW(IW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    ((state == S_DATA) && cap_write && lane_en[g]),
      .idx   (cap_idx),
      .d     (wData[8*g +: 8]),
      .q     (rd_word[g])
    );
  end

  assign rData = ((state == S_DATA) && !cap_write) ? rd_word : '0;
endmodule

// File: tb/tb_ahb_sub_mem.sv
module tb_ahb_sub_mem;
  localparam int DEPTH = 256;

  logic        clk = 0;
  logic        reset;
  logic        sel_s   [2];
  logic        rin_s   [2];
  logic [31:0] addr_s  [2];
  logic [1:0]  trans_s [2];
  logic        write_s [2];
  logic [2:0]  size_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic [1:0]  resp_s  [2];
  logic        rdy_s   [2];

  // Instance 0 has zero wait states. Instance 1 has three.
  ahb_sub_mem #(.WaitStates(0)) u_ws0 (
    .clk(clk), .reset(reset), .sel(sel_s[0]), .readyIn(rin_s[0]),
    .addr(addr_s[0]), .trans(trans_s[0]), .write(write_s[0]), .size(size_s[0]),
    .wData(wdata_s[0]), .rData(rdata_s[0]), .resp(resp_s[0]), .readyOut(rdy_s[0]));

  ahb_sub_mem #(.WaitStates(3)) u_ws3 (
    .clk(clk), .reset(reset), .sel(sel_s[1]), .readyIn(rin_s[1]),
    .addr(addr_s[1]), .trans(trans_s[1]), .write(write_s[1]), .size(size_s[1]),
    .wData(wdata_s[1]), .rData(rdata_s[1]), .resp(resp_s[1]), .readyOut(rdy_s[1]));

  always #5 clk = ~clk;

  int errs = 0;
  int chk  = 0;
  logic [7:0] mb [2][DEPTH*4];   // byte-addressed reference memory per instance

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
    return (sz <= 3'd2) && (a % (32'd1 << sz) == 0) && (a / 4 < DEPTH);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    logic [31:0] w;
    int base;
    base = int'(a & ~32'd3);
    for (int b = 0; b < 4; b++) w[8*b +: 8] = mb[d][base + b];
    return w;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH*4; i++) mb[d][i] = 8'h00;
  endtask

  task automatic idle_bus();
    for (int d = 0; d < 2; d++) begin
      sel_s[d] = 0; rin_s[d] = 1; trans_s[d] = 2'b00; write_s[d] = 0;
      addr_s[d] = '0; size_s[d] = 3'd2; wdata_s[d] = '0;
    end
  endtask

  // Runs one isolated transfer. It starts and ends #1 after a rising edge.
  // The expected timing comes from the legality rules: OKAY = WS low cycles
  // followed by one ready cycle; ERROR = one low cycle then one high cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd);
    int ws;
    ws = (d == 0) ? 0 : 3;
    rd = '0;
    sel_s[d] = 1; rin_s[d] = 1; trans_s[d] = 2'b10;
    write_s[d] = wr; addr_s[d] = a; size_s[d] = sz;
    @(posedge clk); #1;
    sel_s[d] = 0; trans_s[d] = 2'b00; wdata_s[d] = wd;
    if (legal(a, sz)) begin
      for (int k = 0; k < ws; k++) begin
        @(negedge clk);
        check($sformatf("wait_rdy d%0d a%h", d, a), 32'(rdy_s[d]), 32'd0);
        check($sformatf("wait_resp d%0d a%h", d, a), 32'(resp_s[d]), 32'd0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check($sformatf("data_rdy d%0d a%h", d, a), 32'(rdy_s[d]), 32'd1);
      check($sformatf("data_resp d%0d a%h", d, a), 32'(resp_s[d]), 32'd0);
      if (!wr) begin
        rd = rdata_s[d];
        check($sformatf("rdata d%0d a%h", d, a), rdata_s[d], model_word(d, a));
      end
      @(posedge clk); #1;
      if (wr)
        for (int b = 0; b < (1 << sz); b++)
          mb[d][int'(a) + b] = wd[8*((int'(a) + b) % 4) +: 8];
    end else begin
      @(negedge clk);
      check($sformatf("err1_rdy d%0d a%h", d, a), 32'(rdy_s[d]), 32'd0);
      check($sformatf("err1_resp d%0d a%h", d, a), 32'(resp_s[d]), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("err2_rdy d%0d a%h", d, a), 32'(rdy_s[d]), 32'd1);
      check($sformatf("err2_resp d%0d a%h", d, a), 32'(resp_s[d]), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  // Presents a write the subordinate must ignore. The next cycle must be a
  // zero-wait OKAY cycle.
  task automatic noacc(input int d, input logic s, input logic [1:0] tr, input logic rin);
    sel_s[d] = s; rin_s[d] = rin; trans_s[d] = tr;
    write_s[d] = 1; addr_s[d] = 32'h8; size_s[d] = 3'd2;
    @(posedge clk); #1;
    sel_s[d] = 0; rin_s[d] = 1; trans_s[d] = 2'b00; wdata_s[d] = 32'hFFFF_FFFF;
    @(negedge clk);
    check($sformatf("noacc_rdy d%0d", d), 32'(rdy_s[d]), 32'd1);
    check($sformatf("noacc_resp d%0d", d), 32'(resp_s[d]), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    idle_bus();
    clear_model();

    // Reset held for two cycles.
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_rdy d%0d", d), 32'(rdy_s[d]), 32'd1);
      check($sformatf("rst_resp d%0d", d), 32'(resp_s[d]), 32'd0);
      check($sformatf("rst_rdata d%0d", d), rdata_s[d], 32'd0);
    end
    @(posedge clk); #1;
    reset = 0;
    xfer(0, 0, 32'h0, 3'd2, '0, rd);
    check("rst_read0", rd, 32'h0);

    // Zero wait states: a write and a read of the same word, pipelined.
    sel_s[0] = 1; trans_s[0] = 2'b10; write_s[0] = 1; addr_s[0] = 32'h10; size_s[0] = 3'd2;
    @(posedge clk); #1;
    write_s[0] = 0; wdata_s[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("pipe_wr_rdy", 32'(rdy_s[0]), 32'd1);
    @(posedge clk); #1;
    sel_s[0] = 0; trans_s[0] = 2'b00;
    @(negedge clk);
    check("pipe_rd_rdy", 32'(rdy_s[0]), 32'd1);
    check("pipe_rd_data", rdata_s[0], 32'hDEAD_BEEF);
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) mb[0][16 + b] = 8'(32'hDEAD_BEEF >> (8*b));

    // Three wait states: a single read.
    xfer(1, 0, 32'h4, 3'd2, '0, rd);

    // Sized writes merge into one word.
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1, 32'h20, 3'd2, 32'h1122_3344, rd);
      xfer(d, 1, 32'h21, 3'd0, 32'h0000_AA00, rd);
      xfer(d, 1, 32'h22, 3'd1, 32'hBBCC_0000, rd);
      xfer(d, 0, 32'h20, 3'd2, '0, rd);
      check($sformatf("sized_merge d%0d", d), rd, 32'hBBCC_AA44);
    end

    // Illegal accesses: out of range, and a misaligned halfword write.
    for (int d = 0; d < 2; d++) begin
      xfer(d, 0, 32'h400, 3'd2, '0, rd);
      xfer(d, 1, 32'h1, 3'd1, 32'h5555_5555, rd);
      xfer(d, 1, 32'h0, 3'd3, 32'h6666_6666, rd);
      xfer(d, 0, 32'h0, 3'd2, '0, rd);
      check($sformatf("err_mem_unchanged d%0d", d), rd, 32'h0);
    end

    // Transfers the subordinate must ignore: IDLE, BUSY, sel=0, readyIn=0.
    for (int d = 0; d < 2; d++) begin
      noacc(d, 1, 2'b00, 1);
      noacc(d, 1, 2'b01, 1);
      noacc(d, 0, 2'b10, 1);
      noacc(d, 1, 2'b10, 0);
      xfer(d, 0, 32'h8, 3'd2, '0, rd);
      check($sformatf("noacc_mem d%0d", d), rd, 32'h0);
    end

    // Random traffic checked against the reference memory.
    for (int n = 0; n < 120; n++) begin
      int d;
      logic [31:0] a;
      logic [2:0]  sz;
      d  = n % 2;
      sz = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'h3F0 + 32'($urandom_range(0, 31));
      else a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 1);
      xfer(d, 1'($urandom_range(0, 1)), a, sz, $urandom, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset during the wait states of a write drops the write.
    xfer(1, 1, 32'h30, 3'd2, 32'hCAFE_F00D, rd);
    sel_s[1] = 1; trans_s[1] = 2'b10; write_s[1] = 1; addr_s[1] = 32'h34; size_s[1] = 3'd2;
    @(posedge clk); #1;
    sel_s[1] = 0; trans_s[1] = 2'b00; wdata_s[1] = 32'h1234_5678;
    @(negedge clk);
    check("midwait_rdy_low", 32'(rdy_s[1]), 32'd0);
    reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midwait_rst_rdy", 32'(rdy_s[1]), 32'd1);
    check("midwait_rst_resp", 32'(resp_s[1]), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    clear_model();
    xfer(1, 0, 32'h34, 3'd2, '0, rd);
    check("midwait_write_lost", rd, 32'h0);
    xfer(1, 0, 32'h30, 3'd2, '0, rd);
    check("reset_clears_mem", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, chk);
    $finish;
  end
endmodule
